// File: rtl/fetch_queue.sv
// Sequential instruction fetch with an in-order response queue; responses reach decode one cycle after arrival.
// Issue stalls while queue+in-flight would exceed DEPTH; redirect flushes and drops stale responses (trap: FETCH_QUEUE_MISALIGN_TRAP_EN).
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic            fetch_misaligned
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   occ, outst, drop_cnt, outst_nxt;
  logic [AW-1:0]   head, tail, rp_wr, rp_rd;
  logic [XLEN-1:0] q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [XLEN-1:0] rp_mem [DEPTH];
  logic            misaligned;
  logic [CW:0]     in_use;
  logic            req_fire, resp_live, push, pop;
  logic [XLEN-1:0] redirect_tgt;
  logic            redirect_mis;

`ifdef FETCH_QUEUE_MISALIGN_TRAP_EN
  assign redirect_tgt = redirect_pc;
  assign redirect_mis = (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign redirect_mis = 1'b0;
`endif

  assign in_use         = {1'b0, occ} + {1'b0, outst};
  assign imem_req_valid = reset && pc_en && !redirect_valid && !misaligned
                          && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // A response with nothing in flight belongs to a request aborted by reset.
  assign resp_live      = imem_resp_valid && (outst != '0);
  assign push           = resp_live && !redirect_valid && (drop_cnt == '0);
  assign pop            = inst_valid && inst_ready && !redirect_valid;
  assign outst_nxt      = outst + CW'(req_fire) - CW'(resp_live);

  assign inst_valid       = (occ != '0);
  assign inst_data        = inst_valid ? q_data[head] : '0;
  assign inst_pc          = inst_valid ? q_pc[head] : '0;
  assign fetch_misaligned = misaligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      occ        <= '0;
      outst      <= '0;
      drop_cnt   <= '0;
      head       <= '0;
      tail       <= '0;
      rp_wr      <= '0;
      rp_rd      <= '0;
      misaligned <= 1'b0;
    end else begin
      outst <= outst_nxt;
      if (req_fire)  rp_wr <= rp_wr + AW'(1);
      if (resp_live) rp_rd <= rp_rd + AW'(1);
      if (redirect_valid) begin
        pc         <= redirect_tgt;
        misaligned <= redirect_mis;
        occ        <= '0;
        head       <= '0;
        tail       <= '0;
        // Everything still in flight after this edge is from the old path.
        drop_cnt   <= outst_nxt;
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (resp_live && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (req_fire) rp_mem[rp_wr] <= pc;
    if (push) begin
      q_data[tail] <= imem_resp_data;
      q_pc[tail]   <= rp_mem[rp_rd];
    end
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4: instruction queue entries, power of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-low reset (0 = asserted).
REQ-006 SHALL have port pc_en  in  1: fetch enable; 0 = issue no new requests.
REQ-007 SHALL have port redirect_valid  in  1: branch/jump redirect strobe.
REQ-008 SHALL have port redirect_pc  in  XLEN: redirect target.
REQ-009 SHALL have port imem_req_valid  out  1: memory read request.
REQ-010 SHALL have port imem_req_addr  out  XLEN: request address, equal to current PC.
REQ-011 SHALL have port imem_req_ready  in  1: memory accepts the request.
REQ-012 SHALL have port imem_resp_valid  in  1: read data returned, in request order.
REQ-013 SHALL have port imem_resp_data  in  XLEN: instruction word.
REQ-014 SHALL have port inst_valid  out  1: queue head valid.
REQ-015 SHALL have port inst_data  out  XLEN: head instruction.
REQ-016 SHALL have port inst_pc  out  XLEN: head instruction address.
REQ-017 SHALL have port inst_ready  in  1: decode consumes head.
REQ-018 SHALL have port fetch_misaligned  out  1: misaligned-target flag (REQ-035).

Function
REQ-019 SHALL accept a request when imem_req_valid and imem_req_ready are both 1; PC then advances by 4 (wraps modulo 2^XLEN).
REQ-020 SHALL assert imem_req_valid only when pc_en=1, redirect_valid=0, fetch_misaligned=0 and (occupancy + outstanding) < DEPTH.
REQ-021 SHALL keep imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-022 SHALL track outstanding (accepted, unanswered) requests; max DEPTH; no response latency bound (min 1 cycle).
REQ-023 SHALL write each non-dropped response, with its request PC, into the queue tail in the cycle imem_resp_valid=1.
REQ-024 SHALL pop the head when inst_valid and inst_ready are both 1; simultaneous push and pop leave occupancy unchanged.
REQ-025 SHALL present inst_valid registered from the queue: a response is visible at the earliest the cycle after it arrives.
REQ-026 SHALL never overflow: REQ-020 guarantees space; a push onto a full queue is a design error.
REQ-027 SHALL, on redirect_valid=1: flush the queue (inst_valid=0 next cycle), load PC with redirect_pc, and set drop count = outstanding including any request accepted that cycle.
REQ-028 SHALL discard responses while drop count > 0, decrementing per response; a response coincident with redirect_valid is dropped.
REQ-029 SHALL give redirect priority over pop, push and pc_en; PC updates even when pc_en=0.
REQ-030 SHALL, with pc_en=0, keep accepting responses and draining the queue.
REQ-031 SHALL resume issuing the cycle after redirect_valid falls, provided REQ-020 holds.

Reset
REQ-032 SHALL on reset=0 immediately force: PC=RESET_PC, queue empty, outstanding=0, drop count=0, fetch_misaligned=0.
REQ-033 SHALL on reset hold outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
REQ-034 SHALL treat reset mid-transaction as full abort; responses arriving after release and before any new request are ignored.

Configuration
REQ-035 SHALL, with FETCH_QUEUE_MISALIGN_TRAP_EN defined, set fetch_misaligned on redirect with redirect_pc[1:0]!=0, hold it until the next aligned redirect or reset, and issue no requests meanwhile.
REQ-036 SHALL, without FETCH_QUEUE_MISALIGN_TRAP_EN, force redirect_pc[1:0] to 00 and tie fetch_misaligned to 0.

Verification
REQ-037 SHALL cover streaming: reset release, pc_en=1, ready=1, 1-cycle responses -> addrs 0x0,0x4,0x8 issued back-to-back, inst_pc in same order.
REQ-038 SHALL cover backpressure: DEPTH=4, inst_ready=0 -> exactly 4 requests accepted, then imem_req_valid=0 until a pop.
REQ-039 SHALL cover redirect with 2 outstanding: redirect_pc=0x2230 -> queue empties, 2 responses dropped, next request addr 0x2230.
REQ-040 SHALL cover pc_en=0 with redirect_pc=0x5234 -> no requests; after pc_en=1, first addr 0x5234.
REQ-041 SHALL cover misalign: redirect_pc=0x2231 -> fetch_misaligned=1, no requests (macro on); addr 0x2230 issued (macro off).
REQ-042 SHALL cover reset asserted with 3 outstanding -> all outputs at reset values instantly; first post-reset addr RESET_PC.
